// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forward selects and MCU states.
// Imported by hazard_fwd_sel and hazard_ctrl_mc.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MCU_IDLE = 1'b0,
        MCU_BUSY = 1'b1
    } mcu_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage operand: M beats W, x0 never forwards.
// Ports: rs (E source), rd_m/reg_write_m, rd_w/reg_write_w, sel (fwd_sel_e).
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rd_m,
    input  logic          reg_write_m,
    input  logic [AW-1:0] rd_w,
    input  logic          reg_write_w,
    output fwd_sel_e      sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rs != '0) && (rd_m == rs);
    assign hit_w = reg_write_w && (rs != '0) && (rd_w == rs);

    always_comb begin
        sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (hit_m)      sel = FWD_M;
            else if (hit_w) sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: forwarding, stall/flush priority, MCU start/done FSM,
// saturating perf counters. Inputs: D/E/M/W register ids and write/load
// flags, PCSrcE_i, MemReady_i, McuE_i/McuDone_i, PerfClr_i. Outputs: stage
// stalls/flushes, ForwardAE/BE_o, McuStart_o/McuBusy_o, perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int FWD_EN = 1,
    parameter int PERF_W = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AW-1:0]     Rs1D_i,
    input  logic [AW-1:0]     Rs2D_i,
    input  logic [AW-1:0]     Rs1E_i,
    input  logic [AW-1:0]     Rs2E_i,
    input  logic [AW-1:0]     RdE_i,
    input  logic              RegWriteE_i,
    input  logic              LoadE_i,
    input  logic              McuE_i,
    input  logic              PCSrcE_i,
    input  logic [AW-1:0]     RdM_i,
    input  logic              RegWriteM_i,
    input  logic              LoadM_i,
    input  logic              MemReady_i,
    input  logic [AW-1:0]     RdW_i,
    input  logic              RegWriteW_i,
    input  logic              McuDone_i,
    input  logic              PerfClr_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              StallM_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic              FlushM_o,
    output logic              FlushW_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic              McuStart_o,
    output logic              McuBusy_o,
    output logic [PERF_W-1:0] PerfStallCnt_o,
    output logic [PERF_W-1:0] PerfFlushCnt_o
);

    mcu_state_e state;
    mcu_state_e state_nxt;
    fwd_sel_e   fwd_a;
    fwd_sel_e   fwd_b;

    logic mem_stall;
    logic mcu_stall;
    logic dep_stall;
    logic e_hit;
    logic m_hit;

    function automatic logic d_hit(
        input logic [AW-1:0] rd,
        input logic [AW-1:0] s1,
        input logic [AW-1:0] s2
    );
        return (rd != '0) && ((rd == s1) || (rd == s2));
    endfunction

    hazard_fwd_sel #(.AW(AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .rs          (Rs1E_i),
        .rd_m        (RdM_i),
        .reg_write_m (RegWriteM_i),
        .rd_w        (RdW_i),
        .reg_write_w (RegWriteW_i),
        .sel         (fwd_a)
    );

    hazard_fwd_sel #(.AW(AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .rs          (Rs2E_i),
        .rd_m        (RdM_i),
        .reg_write_m (RegWriteM_i),
        .rd_w        (RdW_i),
        .reg_write_w (RegWriteW_i),
        .sel         (fwd_b)
    );

    assign ForwardAE_o = fwd_a;
    assign ForwardBE_o = fwd_b;

    assign e_hit = RegWriteE_i && d_hit(RdE_i, Rs1D_i, Rs2D_i);
    assign m_hit = RegWriteM_i && d_hit(RdM_i, Rs1D_i, Rs2D_i);

    assign mem_stall = LoadM_i && !MemReady_i;
    // Done in BUSY releases E in the same cycle.
    assign mcu_stall = McuE_i
                    && !((state == MCU_BUSY) && McuDone_i);
    // Write-through regfile: W never needs a stall.
    assign dep_stall = (LoadE_i && e_hit)
                    || ((FWD_EN == 0) && (e_hit || m_hit));

    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushM_o = 1'b0;
        FlushW_o = 1'b0;
        if (mem_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (mcu_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            FlushM_o = 1'b1;
        end else if (PCSrcE_i) begin
            // Redirect kills the load-use wait too.
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (dep_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        McuStart_o = 1'b0;
        unique case (state)
            MCU_IDLE: begin
                if (McuE_i && !mem_stall) begin
                    state_nxt  = MCU_BUSY;
                    McuStart_o = 1'b1;
                end
            end
            MCU_BUSY: begin
                if (McuDone_i) state_nxt = MCU_IDLE;
            end
            default: state_nxt = MCU_IDLE;
        endcase
    end

    assign McuBusy_o = (state == MCU_BUSY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= MCU_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            PerfStallCnt_o <= '0;
            PerfFlushCnt_o <= '0;
        end else if (PerfClr_i) begin
            PerfStallCnt_o <= '0;
            PerfFlushCnt_o <= '0;
        end else begin
            if (StallF_o && !(&PerfStallCnt_o))
                PerfStallCnt_o <= PerfStallCnt_o + 1'b1;
            if (FlushD_o && !(&PerfFlushCnt_o))
                PerfFlushCnt_o <= PerfFlushCnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench: two DUTs (forwarding/16-bit, no-forwarding/4-bit)
// share stimulus and are checked against a rule-level reference model.
module tb_hazard_ctrl_mc;

    typedef struct packed {
        logic [3:0]  stl;
        logic [3:0]  fls;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        start;
        logic        busy;
        logic [15:0] pst;
        logic [15:0] pfl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, LoadE, McuE, PCSrcE;
    logic RegWriteM, LoadM, MemReady, RegWriteW;
    logic McuDone, PerfClr;

    logic sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0;
    logic sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic st0, bz0, st1, bz1;
    logic [15:0] ps0, pf0;
    logic [3:0]  ps1, pf1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit mb[2];
    int mps[2];
    int mpf[2];
    int mmax[2] = '{65535, 15};

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.NREG(32), .FWD_EN(1), .PERF_W(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RegWriteE_i(RegWriteE), .LoadE_i(LoadE),
        .McuE_i(McuE), .PCSrcE_i(PCSrcE),
        .RdM_i(RdM), .RegWriteM_i(RegWriteM), .LoadM_i(LoadM),
        .MemReady_i(MemReady), .RdW_i(RdW), .RegWriteW_i(RegWriteW),
        .McuDone_i(McuDone), .PerfClr_i(PerfClr),
        .StallF_o(sF0), .StallD_o(sD0), .StallE_o(sE0), .StallM_o(sM0),
        .FlushD_o(fD0), .FlushE_o(fE0), .FlushM_o(fM0), .FlushW_o(fW0),
        .ForwardAE_o(fa0), .ForwardBE_o(fb0),
        .McuStart_o(st0), .McuBusy_o(bz0),
        .PerfStallCnt_o(ps0), .PerfFlushCnt_o(pf0)
    );

    hazard_ctrl_mc #(.NREG(32), .FWD_EN(0), .PERF_W(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RegWriteE_i(RegWriteE), .LoadE_i(LoadE),
        .McuE_i(McuE), .PCSrcE_i(PCSrcE),
        .RdM_i(RdM), .RegWriteM_i(RegWriteM), .LoadM_i(LoadM),
        .MemReady_i(MemReady), .RdW_i(RdW), .RegWriteW_i(RegWriteW),
        .McuDone_i(McuDone), .PerfClr_i(PerfClr),
        .StallF_o(sF1), .StallD_o(sD1), .StallE_o(sE1), .StallM_o(sM1),
        .FlushD_o(fD1), .FlushE_o(fE1), .FlushM_o(fM1), .FlushW_o(fW1),
        .ForwardAE_o(fa1), .ForwardBE_o(fb1),
        .McuStart_o(st1), .McuBusy_o(bz1),
        .PerfStallCnt_o(ps1), .PerfFlushCnt_o(pf1)
    );

    // A D source reads a register that a pending write will change.
    function automatic bit dsrc(input logic [4:0] rd);
        return rd != 0 && (rd == Rs1D || rd == Rs2D);
    endfunction

    function automatic logic [1:0] pick(input int i, input logic [4:0] rs);
        if (i != 0 || rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model(input int i);
        exp_t e;
        bit mem, mcu, dep;
        e = '0;
        mem = LoadM && !MemReady;
        mcu = McuE && !(mb[i] && McuDone);
        dep = (LoadE && RegWriteE && dsrc(RdE))
           || (i == 1 && ((RegWriteE && dsrc(RdE))
                       || (RegWriteM && dsrc(RdM))));
        if (mem) begin
            e.stl = 4'b1111; e.fls = 4'b0001;
        end else if (mcu) begin
            e.stl = 4'b1110; e.fls = 4'b0010;
        end else if (PCSrcE) begin
            e.fls = 4'b1100;
        end else if (dep) begin
            e.stl = 4'b1100; e.fls = 4'b0100;
        end
        e.fa = pick(i, Rs1E);
        e.fb = pick(i, Rs2E);
        e.start = !mb[i] && McuE && !mem;
        e.busy = mb[i];
        e.pst = 16'(mps[i]);
        e.pfl = 16'(mpf[i]);
        return e;
    endfunction

    // Push this cycle's expectations, then advance the model to the next edge.
    task automatic cyc_end();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = model(i);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (mb[i]) mb[i] = !McuDone;
            else       mb[i] = McuE && !(LoadM && !MemReady);
            if (PerfClr) begin
                mps[i] = 0; mpf[i] = 0;
            end else begin
                if (e.stl[3]) mps[i] = (mps[i] < mmax[i]) ? mps[i] + 1 : mps[i];
                if (e.fls[3]) mpf[i] = (mpf[i] < mmax[i]) ? mpf[i] + 1 : mpf[i];
            end
        end
    endtask

    task automatic zero_in();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, LoadE, McuE, PCSrcE} = '0;
        {RegWriteM, LoadM, RegWriteW, McuDone, PerfClr} = '0;
        MemReady = 1'b1;
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        cyc++;
        zero_in();
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        zero_in();
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; mps[i] = 0; mpf[i] = 0;
        end
        q0.push_back(model(0));
        q1.push_back(model(1));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic rand_in();
        Rs1D = 5'($urandom_range(0, 7));
        Rs2D = 5'($urandom_range(0, 7));
        Rs1E = 5'($urandom_range(0, 7));
        Rs2E = 5'($urandom_range(0, 7));
        RdE = 5'($urandom_range(0, 7));
        RdM = 5'($urandom_range(0, 7));
        RdW = 5'($urandom_range(0, 7));
        RegWriteE = 1'($urandom_range(0, 1));
        LoadE = 1'($urandom_range(0, 1));
        McuE = ($urandom_range(0, 3) == 0);
        PCSrcE = ($urandom_range(0, 4) == 0);
        RegWriteM = 1'($urandom_range(0, 1));
        LoadM = ($urandom_range(0, 3) == 0);
        MemReady = ($urandom_range(0, 2) != 0);
        RegWriteW = 1'($urandom_range(0, 1));
        McuDone = ($urandom_range(0, 2) == 0);
        PerfClr = ($urandom_range(0, 40) == 0);
    endtask

    function automatic exp_t act(input int i);
        exp_t a;
        if (i == 0) begin
            a.stl = {sF0, sD0, sE0, sM0};
            a.fls = {fD0, fE0, fM0, fW0};
            a.fa = fa0; a.fb = fb0; a.start = st0; a.busy = bz0;
            a.pst = ps0; a.pfl = pf0;
        end else begin
            a.stl = {sF1, sD1, sE1, sM1};
            a.fls = {fD1, fE1, fM1, fW1};
            a.fa = fa1; a.fb = fb1; a.start = st1; a.busy = bz1;
            a.pst = {12'd0, ps1}; a.pfl = {12'd0, pf1};
        end
        return a;
    endfunction

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 ? q0.size() : q1.size()) != 0) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                a = act(i);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scb dut%0d cyc %0d got %h want %h",
                             i, cyc, a, e);
                end
            end
        end
    end

    initial begin
        zero_in();
        do_reset();

        // Forward priority M over W; x0 never forwards.
        cyc_begin(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        cyc_end(); @(negedge clk); chk("fwd_m", int'(fa0), 2);
        cyc_begin(); Rs1E = 0; RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1;
        cyc_end(); @(negedge clk); chk("fwd_x0", int'(fa0), 0);

        // Load-use, then x0 load-use.
        cyc_begin(); LoadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
        cyc_end(); @(negedge clk); chk("lu_stall", int'({sF0, sD0, fE0}), 7);
        cyc_begin(); LoadE = 1; RegWriteE = 1; RdE = 0; Rs2D = 0;
        cyc_end(); @(negedge clk); chk("lu_x0", int'(sF0), 0);

        // MCU op with done after 4 BUSY cycles.
        cyc_begin(); PerfClr = 1; cyc_end();
        for (int k = 0; k < 6; k++) begin
            cyc_begin(); McuE = 1; McuDone = (k == 5); cyc_end();
        end
        cyc_begin(); cyc_end();
        @(negedge clk); chk("mcu_perf", int'(ps0), 5);

        // Memory wait hides a branch until released.
        for (int k = 0; k < 4; k++) begin
            cyc_begin(); LoadM = 1; PCSrcE = 1; MemReady = (k == 3);
            cyc_end();
            @(negedge clk);
            chk("mem_flushd", int'(fD0), (k == 3) ? 1 : 0);
        end

        // No forwarding: M match stalls.
        cyc_begin(); RdM = 3; RegWriteM = 1; Rs1D = 3; Rs1E = 3;
        cyc_end(); @(negedge clk);
        chk("nofwd_stall", int'({sF1, sD1}), 3);
        chk("nofwd_fa", int'(fa1), 0);

        for (int k = 0; k < 600; k++) begin
            cyc_begin(); rand_in(); cyc_end();
        end

        // Reset while BUSY.
        cyc_begin(); McuE = 1; cyc_end();
        cyc_begin(); McuE = 1; cyc_end();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cyc_begin(); cyc_end();
            @(negedge clk);
            chk("rst_busy", int'(bz0), 0);
            chk("rst_start", int'(st0), 0);
        end

        // Saturation on the narrow counter, then clear beats increment.
        for (int k = 0; k < 20; k++) begin
            cyc_begin(); LoadM = 1; MemReady = 0; cyc_end();
        end
        cyc_begin(); LoadM = 1; MemReady = 0; PerfClr = 1; cyc_end();
        @(negedge clk);
        chk("sat_narrow", int'(ps1), 15);
        chk("sat_wide", int'(ps0), 20);
        cyc_begin(); cyc_end();
        @(negedge clk);
        chk("clr_wins", int'(ps1), 0);

        repeat (3) @(posedge clk);
        chk("scb_drain", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
